// File: rtl/cnn_pixel_streamer_if.sv
// Host and CNN-facing signal bundle for cnn_pixel_streamer.
// master drives writes/start/CNN results; slave is the streamer.
interface cnn_pixel_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     start;
  logic                     busy;
  logic                     pix_valid;
  logic signed [DATA_W-1:0] pix_data;
  logic                     fc_done;
  logic [3:0]               fc_digit;
  logic                     result_valid;
  logic [3:0]               result_digit;
  logic                     timeout;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    output fc_done, fc_digit,
    input  busy, pix_valid, pix_data,
    input  result_valid, result_digit, timeout
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    input  fc_done, fc_digit,
    output busy, pix_valid, pix_data,
    output result_valid, result_digit, timeout
  );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// Frame-buffer pixel streamer feeding the CNN; returns its class.
// Optional WAIT_RES abort timer: define CNN_STREAM_TIMEOUT_EN.
module cnn_pixel_streamer #(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65536
) (
  input logic             clk,
  input logic             rst_n,
  cnn_pixel_streamer_if.slave bus
);
  localparam int N  = IMG_W * IMG_H;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE, PREFETCH, STREAM, WAIT_RES
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] pcnt;
  logic              wr_ok;
  logic              got_res;
  logic              tmo_hit;

  assign wr_ok   = (state == IDLE) && bus.wr_en &&
                   !bus.start && (bus.wr_addr <= LAST);
  assign got_res = (state == WAIT_RES) && bus.fc_done;
  assign bus.busy = (state != IDLE);

  // Buffer is never cleared so frames persist across reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
    rd_q <= mem[raddr];
  end

`ifdef CNN_STREAM_TIMEOUT_EN
  logic [TW-1:0] tcnt;

  assign tmo_hit = (state == WAIT_RES) && !bus.fc_done &&
                   (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tcnt <= '0;
    else if (state != WAIT_RES) tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end
`else
  logic [TW-1:0] unused_tmo_cfg;

  assign unused_tmo_cfg = TW'(TIMEOUT_CYC);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (bus.start) state_d = PREFETCH;
      PREFETCH: state_d = STREAM;
      STREAM:   if (pcnt == LAST) state_d = WAIT_RES;
      WAIT_RES: if (got_res || tmo_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // raddr runs one ahead of the presented pixel (pcnt).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr <= '0;
      pcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          raddr <= '0;
          pcnt  <= '0;
        end
        PREFETCH: raddr <= ADDR_W'(1);
        STREAM: begin
          if (raddr != LAST) raddr <= raddr + 1'b1;
          if (pcnt != LAST)  pcnt  <= pcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pix_valid    <= 1'b0;
      bus.pix_data     <= '0;
      bus.result_valid <= 1'b0;
      bus.result_digit <= '0;
      bus.timeout      <= 1'b0;
    end else begin
      bus.pix_valid    <= (state == STREAM);
      bus.pix_data     <= (state == STREAM) ? rd_q : '0;
      bus.result_valid <= got_res;
      bus.timeout      <= tmo_hit;
      if (got_res)      bus.result_digit <= bus.fc_digit;
      else if (tmo_hit) bus.result_digit <= 4'hF;
    end
  end
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Directed/random bench for cnn_pixel_streamer with array model.
module tb_cnn_pixel_streamer;
  localparam int N = 784;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnn_pixel_streamer_if #(.DATA_W(8), .ADDR_W(10)) bus();

  cnn_pixel_streamer #(
    .DATA_W(8), .IMG_W(28), .IMG_H(28),
    .ADDR_W(10), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic signed [7:0] ref_mem [N];
  logic [3:0]        last_digit;
  int total = 0;
  int bad   = 0;
  bit ab;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic signed [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 10'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (a < N) ref_mem[a] = d;
  endtask

  task automatic run_frame(input bit inject, input int abort_at,
                           output bit aborted);
    aborted   = 1'b0;
    bus.start = 1'b1;
    if (inject) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 10'd0;
      bus.wr_data = 8'sd99;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("pv_lat1", 32'(bus.pix_valid), 0);
    @(negedge clk);
    chk("pv_lat2", 32'(bus.pix_valid), 0);
    chk("pd_lat2", 32'(bus.pix_data), 0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.wr_en   = 1'b0;
      bus.fc_done = 1'b0;
      chk("pix_valid", 32'(bus.pix_valid), 1);
      chk("pix_data", 32'(bus.pix_data), 32'(ref_mem[k]));
      if (k == 21 || k == 22)
        chk("rv_in_stream", 32'(bus.result_valid), 0);
      if (inject && k == 10) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 10'd5;
        bus.wr_data = -8'sd3;
      end
      if (inject && k == 20) begin
        bus.fc_done  = 1'b1;
        bus.fc_digit = 4'hA;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_pv", 32'(bus.pix_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pd", 32'(bus.pix_data), 0);
        chk("rst_digit", 32'(bus.result_digit), 0);
        last_digit = 4'h0;
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("pv_end", 32'(bus.pix_valid), 0);
    chk("pd_end", 32'(bus.pix_data), 0);
    chk("busy_wait", 32'(bus.busy), 1);
  endtask

  task automatic finish(input int delay, input logic [3:0] d,
                        input bit inject);
    for (int i = 0; i < delay; i++) begin
      chk("rv_wait", 32'(bus.result_valid), 0);
      chk("busy_wait", 32'(bus.busy), 1);
      chk("pv_wait", 32'(bus.pix_valid), 0);
      chk("timeout_wait", 32'(bus.timeout), 0);
      if (inject && i == 10) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.fc_done  = 1'b1;
    bus.fc_digit = d;
    @(negedge clk);
    bus.fc_done = 1'b0;
    chk("rv_pulse", 32'(bus.result_valid), 1);
    chk("busy_fall", 32'(bus.busy), 0);
    chk("digit", 32'(bus.result_digit), 32'(d));
    last_digit = d;
    @(negedge clk);
    chk("rv_single", 32'(bus.result_valid), 0);
    chk("digit_held", 32'(bus.result_digit), 32'(d));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.fc_done  = 1'b0;
    bus.fc_digit = '0;
    last_digit   = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pv", 32'(bus.pix_valid), 0);
    chk("rst_pd", 32'(bus.pix_data), 0);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk("rst_digit", 32'(bus.result_digit), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < N; a++) load(a, 8'(a % 128));

    run_frame(1'b1, -1, ab);
    finish(50, 4'd7, 1'b1);

    bus.fc_done  = 1'b1;
    bus.fc_digit = 4'd3;
    @(negedge clk);
    bus.fc_done = 1'b0;
    chk("idle_fc_rv", 32'(bus.result_valid), 0);
    chk("idle_fc_digit", 32'(bus.result_digit), 32'(last_digit));
    @(negedge clk);
    chk("idle_fc_rv2", 32'(bus.result_valid), 0);

    run_frame(1'b0, -1, ab);
    finish(5, 4'd2, 1'b0);

    for (int a = 0; a < N; a++) load(a, 8'($urandom));
    run_frame(1'b0, 300, ab);
    chk("aborted", 32'(ab), 1);
    run_frame(1'b0, -1, ab);
    finish(3, 4'($urandom), 1'b0);

`ifdef CNN_STREAM_TIMEOUT_EN
    run_frame(1'b0, -1, ab);
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      chk("to_pulse", 32'(bus.timeout), 32'(i == 98));
      chk("to_rv", 32'(bus.result_valid), 0);
    end
    chk("to_digit", 32'(bus.result_digit), 32'hF);
    chk("to_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("to_single", 32'(bus.timeout), 0);

    run_frame(1'b0, -1, ab);
    for (int i = 0; i < 98; i++) begin
      @(negedge clk);
      chk("to_pre", 32'(bus.timeout), 0);
    end
    bus.fc_done  = 1'b1;
    bus.fc_digit = 4'd6;
    @(negedge clk);
    bus.fc_done = 1'b0;
    chk("edge_rv", 32'(bus.result_valid), 1);
    chk("edge_to", 32'(bus.timeout), 0);
    chk("edge_digit", 32'(bus.result_digit), 6);
    @(negedge clk);
    chk("edge_to2", 32'(bus.timeout), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cnn_pixel_streamer.md
# cnn_pixel_streamer

Frame-buffer-backed pixel transmitter that drives the `valid_in`/`data_in` input of `cnn_multichannel_top`. It sits between the host side and the CNN top. A host loads one 28×28 signed 8-bit image through a simple write port and pulses `start`. The block then streams all pixels in raster order as one contiguous valid burst. It waits for the CNN's `fc_done`, captures `final_digit`, and reports it back to the host.

## Interface
Parameters:
- `DATA_W`, 8: pixel width (signed).
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `ADDR_W`, 10: frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `TIMEOUT_CYC`, 65536: cycles to wait for `fc_done` before abort (used only with the macro).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: frame-buffer write strobe.
- `wr_addr` in ADDR_W: write address, raster order (row*IMG_W+col).
- `wr_data` in DATA_W: signed pixel value.
- `start` in 1: begin a frame (level sampled each cycle).
- `busy` out 1: high from start acceptance until return to IDLE.
- `pix_valid` out 1: to CNN `valid_in`.
- `pix_data` out DATA_W: to CNN `data_in`, signed.
- `fc_done` in 1: from CNN `fc_done`.
- `fc_digit` in 4: from CNN `final_digit`.
- `result_valid` out 1: one-cycle pulse on result capture.
- `result_digit` out 4: captured class, held until next capture.
- `timeout` out 1: one-cycle abort pulse (tied 0 without the macro).

## Operation
- Frame buffer: IMG_W*IMG_H × DATA_W memory with synchronous read. It is written only in IDLE with `wr_en`=1 and `wr_addr` < IMG_W*IMG_H. Writes in any other state or out of range are dropped silently.
- FSM states: IDLE, PREFETCH, STREAM, WAIT_RES.
  - IDLE: `busy`=0. On `start`=1 the block issues a read of address 0 and goes to PREFETCH. A `wr_en` in the same cycle as `start` is dropped.
  - PREFETCH: one cycle for the read to complete; the read address advances to 1; goes to STREAM.
  - STREAM: registers the memory output to `pix_data` with `pix_valid`=1. It issues a read of the next address each cycle. After presenting pixel IMG_W*IMG_H-1 it goes to WAIT_RES; `pix_valid` is 0 from the next cycle on.
  - WAIT_RES: `pix_valid`=0. On `fc_done`=1 it latches `fc_digit` into `result_digit`, pulses `result_valid` for one cycle, and returns to IDLE.
- The pixel counter is 0..IMG_W*IMG_H-1 with no wrap. The terminal count ends the burst and is never exceeded.
- `start` is ignored when not in IDLE.
- `fc_done` is ignored outside WAIT_RES, so stale or late completions never produce `result_valid`.
- `pix_data` is 0 whenever `pix_valid`=0.
- Frame contents persist across frames; re-streaming without reload sends identical data.

## Timing
- Reset values: `busy`=0, `pix_valid`=0, `pix_data`=0, `result_valid`=0, `result_digit`=0, `timeout`=0, FSM=IDLE, counters 0. Frame-buffer contents are not cleared.
- Let E be the rising edge that samples `start`=1 in IDLE:
  - `busy` is 1 after E.
  - `pix_valid` rises after edge E+2 and stays high for exactly IMG_W*IMG_H consecutive cycles (784 by default), with no gaps.
  - Pixel k is presented after edge E+2+k.
- `result_valid` is high in the cycle after the edge that samples `fc_done`=1 in WAIT_RES. `busy` falls at that same edge. A new `start` is accepted at the following edge.
- Reset mid-burst: outputs return to reset values asynchronously and the burst is truncated. The downstream CNN also resets on the shared `rst_n`.

## Configuration
- `CNN_STREAM_TIMEOUT_EN` defined:
  - A counter runs in WAIT_RES. If TIMEOUT_CYC cycles pass without `fc_done`, the block pulses `timeout` for one cycle, sets `result_digit`=4'hF, does not assert `result_valid`, and returns to IDLE.
  - `fc_done` on the terminal cycle wins over the timeout.
- Not defined: WAIT_RES waits indefinitely and `timeout` is constant 0.

## Test plan
- Load pixels with value = addr[6:0] (signed) at addresses 0..783, then pulse `start` → `pix_valid` high for exactly 784 contiguous cycles starting 2 edges after `start`, with `pix_data` sequence 0,1,…,127,0,1,… in raster order.
- Drive `fc_done`=1 with `fc_digit`=7, 50 cycles after burst end → `result_valid` is a single-cycle pulse and `result_digit`=7 held; `busy` falls at the same edge.
- Assert `wr_en` (addr 5, data −3) during STREAM, and `start` during WAIT_RES → no memory change (re-stream shows the original value at index 5) and no restart.
- Assert `fc_done` in IDLE and during STREAM → no `result_valid` and `result_digit` unchanged.
- Assert `rst_n`=0 at pixel 300 → `pix_valid`/`busy` drop immediately. After reset release, `start` streams the full 784 pixels with the preloaded data intact.
- With `CNN_STREAM_TIMEOUT_EN` and TIMEOUT_CYC=100, withhold `fc_done` → `timeout` pulses 100 cycles into WAIT_RES and `result_digit`=4'hF. With `fc_done` on cycle 100 instead → `result_valid` fires and there is no timeout.
